// File: rtl/div_pkg.sv
// Shared widths, FSM state type and constants for the 16x8 sequential divider.
package div_pkg;
    localparam int DW_N  = 16;
    localparam int DW_D  = 8;
    localparam int CNT_W = $clog2(DW_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DW_N-1:0] DBZ_QUOTIENT = '1;
endpackage

// File: rtl/div_16x8_seq_if.sv
// Operand and result handshake bundle for the sequential divider.
// A transfer happens on a rising edge where valid and ready are both high; once raised, valid and its data hold until that edge.
interface div_16x8_seq_if;
    import div_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [DW_N-1:0] N;
    logic [DW_D-1:0] D;
    logic            out_valid;
    logic            out_ready;
    logic [DW_N-1:0] Q;
    logic [DW_D-1:0] REM;
    logic            dbz;

    modport master (
        output in_valid, N, D, out_ready,
        input  in_ready, out_valid, Q, REM, dbz
    );

    modport slave (
        input  in_valid, N, D, out_ready,
        output in_ready, out_valid, Q, REM, dbz
    );
endinterface

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the divisor when it fits.
module div_restore_step #(
    parameter int DW_D = 8
) (
    input  logic [DW_D-1:0] pr_in,
    input  logic            n_bit,
    input  logic [DW_D-1:0] d,
    output logic [DW_D-1:0] pr_out,
    output logic            q_bit
);
    logic [DW_D:0] pr_sh;

    // The difference is always below d, so modulo-2^DW_D subtraction gives the exact remainder.
    always_comb begin
        pr_sh  = {pr_in, n_bit};
        q_bit  = (pr_sh >= {1'b0, d});
        pr_out = q_bit ? (pr_sh[DW_D-1:0] - d) : pr_sh[DW_D-1:0];
    end
endmodule

// File: rtl/div_16x8_seq.sv
// Radix-2 restoring divider, 16-bit dividend by 8-bit divisor, one quotient bit per clock.
module div_16x8_seq
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    div_16x8_seq_if.slave  bus,
    output state_t         state_dbg
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [DW_N-1:0]  nq;
    logic [DW_D-1:0]  dreg;
    logic [DW_D-1:0]  pr;
    logic [DW_D-1:0]  pr_next;
    logic             q_bit;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [DW_N-1:0]  q_r;
    logic [DW_D-1:0]  rem_r;
    logic             dbz_r;

    div_restore_step #(.DW_D(DW_D)) u_step (
        .pr_in  (pr),
        .n_bit  (nq[DW_N-1]),
        .d      (dreg),
        .pr_out (pr_next),
        .q_bit  (q_bit)
    );

    // nq starts as the dividend and fills from the bottom with quotient bits as dividend bits leave the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            nq          <= '0;
            dreg        <= '0;
            pr          <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            q_r         <= '0;
            rem_r       <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        if (bus.D == '0) begin
                            q_r         <= DBZ_QUOTIENT;
                            rem_r       <= bus.N[DW_D-1:0];
                            dbz_r       <= 1'b1;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            nq    <= bus.N;
                            dreg  <= bus.D;
                            pr    <= '0;
                            cnt   <= CNT_W'(DW_N - 1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    pr  <= pr_next;
                    nq  <= {nq[DW_N-2:0], q_bit};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        q_r         <= {nq[DW_N-2:0], q_bit};
                        rem_r       <= pr_next;
                        dbz_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.Q         = q_r;
    assign bus.REM       = rem_r;
    assign bus.dbz       = dbz_r;
    assign state_dbg     = state;
endmodule

// File: tb/tb_div_16x8_seq.sv
// Directed bench for div_16x8_seq: latency, divide-by-zero, backpressure, async reset and back-to-back throughput.
module tb_div_16x8_seq;
    import div_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t state_dbg;

    div_16x8_seq_if dif ();

    div_16x8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (dif.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int test_cnt = 0;
    int fail_cnt = 0;
    logic [24:0] exp_q[$];
    logic [15:0] tn[$];
    logic [7:0]  td[$];
    int cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] model(input logic [15:0] n, input logic [7:0] d);
        logic [15:0] dd;
        logic [15:0] rr;
        if (d == 8'd0) return {16'hFFFF, n[7:0], 1'b1};
        dd = {8'd0, d};
        rr = n % dd;
        return {n / dd, rr[7:0], 1'b0};
    endfunction

    task automatic send(input logic [15:0] n, input logic [7:0] d);
        int guard = 0;
        @(negedge clk);
        dif.N = n;
        dif.D = d;
        dif.in_valid = 1'b1;
        while (!dif.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", 32'(guard < 100), 32'd1);
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
    endtask

    task automatic get(input string tag, input bit ack, input logic [15:0] eq,
                       input logic [7:0] er, input logic ed, output int cycles);
        cycles = 0;
        while (cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (dif.out_valid) break;
        end
        check({tag, "_valid"}, 32'(dif.out_valid), 32'd1);
        check({tag, "_q"}, 32'(dif.Q), 32'(eq));
        check({tag, "_rem"}, 32'(dif.REM), 32'(er));
        check({tag, "_dbz"}, 32'(dif.dbz), 32'(ed));
        if (ack) begin
            dif.out_ready = 1'b1;
            @(posedge clk);
            #1 dif.out_ready = 1'b0;
            check({tag, "_drop"}, 32'(dif.out_valid), 32'd0);
        end
    endtask

    initial begin
        int idx;
        int got;
        int guard;
        int last_acc;
        bit prev_dbz;
        logic [24:0] e;

        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b0;
        dif.N = '0;
        dif.D = '0;

        // Reset values
        #12;
        check("rst_in_ready", 32'(dif.in_ready), 32'd1);
        check("rst_out_valid", 32'(dif.out_valid), 32'd0);
        check("rst_q", 32'(dif.Q), 32'd0);
        check("rst_rem", 32'(dif.REM), 32'd0);
        check("rst_dbz", 32'(dif.dbz), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        send(16'd65025, 8'd255);
        get("n65025_d255", 1'b1, 16'd255, 8'd0, 1'b0, cyc);
        check("lat_normal", 32'(cyc), 32'd17);
        send(16'd1000, 8'd7);
        get("n1000_d7", 1'b1, 16'd142, 8'd6, 1'b0, cyc);
        send(16'd65535, 8'd1);
        get("n65535_d1", 1'b1, 16'd65535, 8'd0, 1'b0, cyc);
        send(16'd5, 8'd200);
        get("n5_d200", 1'b1, 16'd0, 8'd5, 1'b0, cyc);
        send(16'h1234, 8'd0);
        get("dbz", 1'b1, 16'hFFFF, 8'h34, 1'b1, cyc);
        check("lat_dbz", 32'(cyc), 32'd1);

        // Backpressure: 40000 / 123 = 325 rem 25
        send(16'd40000, 8'd123);
        get("bp", 1'b0, 16'd325, 8'd25, 1'b0, cyc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(dif.out_valid), 32'd1);
            check("bp_in_ready", 32'(dif.in_ready), 32'd0);
            check("bp_q", 32'(dif.Q), 32'd325);
            check("bp_rem", 32'(dif.REM), 32'd25);
            check("bp_state", 32'(state_dbg), 32'(DONE));
            dif.in_valid = i[0];
            dif.N = 16'($urandom_range(0, 65535));
            dif.D = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        check("bp_release_valid", 32'(dif.out_valid), 32'd0);
        check("bp_release_ready", 32'(dif.in_ready), 32'd1);
        check("bp_release_state", 32'(state_dbg), 32'(IDLE));
        send(16'd300, 8'd17);
        get("after_bp", 1'b1, 16'd17, 8'd11, 1'b0, cyc);

        // Asynchronous reset in the middle of CALC
        send(16'd50000, 8'd3);
        repeat (8) @(negedge clk);
        check("abort_state_calc", 32'(state_dbg), 32'(CALC));
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(dif.in_ready), 32'd1);
        check("abort_out_valid", 32'(dif.out_valid), 32'd0);
        check("abort_q", 32'(dif.Q), 32'd0);
        check("abort_rem", 32'(dif.REM), 32'd0);
        check("abort_dbz", 32'(dif.dbz), 32'd0);
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        repeat (2) @(negedge clk);
        check("abort_hold_valid", 32'(dif.out_valid), 32'd0);
        rst_n = 1'b1;
        send(16'd100, 8'd9);
        get("after_abort", 1'b1, 16'd11, 8'd1, 1'b0, cyc);

        // Back-to-back at maximum throughput, corners then random pairs
        tn = '{16'd0, 16'd65535, 16'd0, 16'd65535, 16'd255, 16'd254, 16'd65534, 16'd128};
        td = '{8'd255, 8'd255, 8'd1, 8'd0, 8'd255, 8'd255, 8'd2, 8'd0};
        for (int i = 0; i < 150; i++) begin
            tn.push_back(16'($urandom_range(0, 65535)));
            td.push_back(8'($urandom_range(0, 255)));
        end
        dif.out_ready = 1'b1;
        idx = 0;
        got = 0;
        guard = 0;
        last_acc = 0;
        prev_dbz = 1'b0;
        while (got < tn.size() && guard < tn.size() * 20 + 100) begin
            @(negedge clk);
            guard++;
            if (dif.out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h0;
                check("b2b_q", 32'(dif.Q), 32'(e[24:9]));
                check("b2b_rem", 32'(dif.REM), 32'(e[8:1]));
                check("b2b_dbz", 32'(dif.dbz), 32'(e[0]));
                got++;
            end
            if (dif.in_ready && idx < tn.size()) begin
                if (idx > 0) check("b2b_spacing", 32'(guard - last_acc), prev_dbz ? 32'd2 : 32'd18);
                dif.N = tn[idx];
                dif.D = td[idx];
                dif.in_valid = 1'b1;
                exp_q.push_back(model(tn[idx], td[idx]));
                prev_dbz = (td[idx] == 8'd0);
                last_acc = guard;
                idx++;
            end else begin
                dif.in_valid = 1'b0;
            end
        end
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b0;
        check("b2b_count", 32'(got), 32'(tn.size()));

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
